// File: rtl/asrm_timer_periph.sv
// asrm_timer_periph: memory-mapped down-counting timer on the ASRM system bus.
// Five word-aligned registers (CTRL, RELOAD, COUNT, STATUS, PRESC) sit at base_addr.
// A prescaler divides the clock into ticks; each tick decrements COUNT and the
// tick that finds COUNT at zero flags expiry (EXP), optionally reloading.
// irq is the level EXP & IE. Read data is registered and is zero when the
// address selects nothing, so several responders can be OR-ed onto the bus.
module asrm_timer_periph #(
    parameter int unsigned          wordsize  = 16,
    parameter logic [wordsize-1:0]  base_addr = 'hFF00
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    output logic                irq
);

    // Byte distance between consecutive registers.
    localparam int unsigned         step   = wordsize / 8;
    localparam logic [wordsize-1:0] step_w = wordsize'(step);

    // Register indices inside the map.
    localparam int unsigned reg_ctrl   = 0;
    localparam int unsigned reg_reload = 1;
    localparam int unsigned reg_count  = 2;
    localparam int unsigned reg_status = 3;
    localparam int unsigned reg_presc  = 4;
    localparam int unsigned num_regs   = 5;

    // Architectural state.
    logic                en_q, en_d;
    logic                auto_q, auto_d;
    logic                ie_q, ie_d;
    logic                exp_q, exp_d;
    logic [wordsize-1:0] reload_q, reload_d;
    logic [wordsize-1:0] count_q, count_d;
    logic [wordsize-1:0] presc_q, presc_d;
    logic [wordsize-1:0] pcnt_q, pcnt_d;
    logic [wordsize-1:0] data_out_q, data_out_d;

    // Decode and control intermediates.
    logic [wordsize-1:0] off;
    logic [wordsize-1:0] reg_idx;
    logic                aligned;
    logic [num_regs-1:0] sel;
    logic                wr_ctrl;
    logic                wr_reload;
    logic                wr_count;
    logic                wr_status;
    logic                wr_presc;
    logic                pcnt_wrap;
    logic                tick;
    logic                expire;

    // Address decode: offset from base, must be a whole register step and within the map.
    always_comb begin
        off     = addr - base_addr;
        reg_idx = off / step_w;
        aligned = ((off % step_w) == '0);
        sel     = '0;
        for (int n = 0; n < int'(num_regs); n++) begin
            sel[n] = aligned && (reg_idx == wordsize'(n));
        end
        wr_ctrl   = write_en && sel[reg_ctrl];
        wr_reload = write_en && sel[reg_reload];
        wr_count  = write_en && sel[reg_count];
        wr_status = write_en && sel[reg_status];
        wr_presc  = write_en && sel[reg_presc];
    end

    // Prescaler: counts while enabled, wraps at PRESC to emit a tick; CTRL/COUNT writes restart it
    // and also suppress the tick so the bus write wins that cycle.
    always_comb begin
        pcnt_wrap = (pcnt_q == presc_q);
        tick      = 1'b0;
        pcnt_d    = pcnt_q;
        if (en_q) begin
            if (pcnt_wrap) begin
                pcnt_d = '0;
                tick   = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
        if (wr_ctrl || wr_count) begin
            pcnt_d = '0;
            tick   = 1'b0;
        end
    end

    // Timer registers: tick effects first, then bus writes override; an expiry beats a clear of EXP.
    always_comb begin
        en_d     = en_q;
        auto_d   = auto_q;
        ie_d     = ie_q;
        exp_d    = exp_q;
        reload_d = reload_q;
        count_d  = count_q;
        presc_d  = presc_q;
        expire   = 1'b0;

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                expire = 1'b1;
                if (auto_q) begin
                    // The old RELOAD value is used even if RELOAD is being written now.
                    count_d = reload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (wr_ctrl) begin
            en_d   = data_in[0];
            auto_d = data_in[1];
            ie_d   = data_in[2];
        end
        if (wr_reload) begin
            reload_d = data_in;
        end
        if (wr_count) begin
            count_d = data_in;
        end
        if (wr_presc) begin
            presc_d = data_in;
        end
        if (wr_status && data_in[0]) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
        end
    end

    // Read mux: returns the post-update value of the selected register, zero when nothing is selected.
    always_comb begin
        data_out_d = '0;
        if (sel[reg_ctrl]) begin
            data_out_d[2:0] = {ie_d, auto_d, en_d};
        end
        if (sel[reg_reload]) begin
            data_out_d = reload_d;
        end
        if (sel[reg_count]) begin
            data_out_d = count_d;
        end
        if (sel[reg_status]) begin
            data_out_d[0] = exp_d;
        end
        if (sel[reg_presc]) begin
            data_out_d = presc_d;
        end
    end

    // State register with synchronous active-low reset; reset abandons any count in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            exp_q      <= 1'b0;
            reload_q   <= '0;
            count_q    <= '0;
            presc_q    <= '0;
            pcnt_q     <= '0;
            data_out_q <= '0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            exp_q      <= exp_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign irq      = exp_q & ie_q;

endmodule

// File: tb/tb_asrm_timer_periph.sv
// Directed bench for asrm_timer_periph: reset, one-shot, auto-reload, clear race,
// address decode and reset in the middle of a count.
module tb_asrm_timer_periph;

  localparam int W = 16;
  localparam logic [W-1:0] BASE = 16'hFF00;
  localparam logic [W-1:0] A_CTRL   = 16'hFF00;
  localparam logic [W-1:0] A_RELOAD = 16'hFF02;
  localparam logic [W-1:0] A_COUNT  = 16'hFF04;
  localparam logic [W-1:0] A_STATUS = 16'hFF06;
  localparam logic [W-1:0] A_PRESC  = 16'hFF08;

  // clock / reset
  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] addr;
  logic [W-1:0] data_in;
  logic         write_en;
  logic [W-1:0] data_out;
  logic         irq;

  always #5 clk = ~clk;

  asrm_timer_periph #(.wordsize(W), .base_addr(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_in  (data_in),
    .write_en (write_en),
    .data_out (data_out),
    .irq      (irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  // irq watcher used during the mid-count reset test
  logic mon_en = 1'b0;
  int   irq_hits = 0;
  always @(negedge clk) if (mon_en && irq) irq_hits++;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at a negedge
  task automatic bus_write(input logic [W-1:0] a, input logic [W-1:0] d);
    addr = a;
    data_in = d;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [W-1:0] a, output logic [W-1:0] v);
    addr = a;
    write_en = 1'b0;
    @(negedge clk);
    v = data_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [W-1:0] rd;
  logic [W-1:0] reg_addrs [5];
  logic [W-1:0] reg_exp   [5];
  logic [W-1:0] bad_addrs [3];

  initial begin
    reg_addrs = '{A_CTRL, A_RELOAD, A_COUNT, A_STATUS, A_PRESC};
    bad_addrs = '{16'hFF01, 16'hFF0A, 16'hFEFE};
    reset = 1'b0;
    addr = A_COUNT;
    data_in = '0;
    write_en = 1'b0;

    // 1. reset
    idle(2);
    check("rst_data_out", data_out, 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_read(reg_addrs[i], rd);
      check($sformatf("rst_reg%0d", i), rd, 16'h0000);
    end
    check("rst_irq", {15'b0, irq}, 16'h0000);

    // 2. one-shot: expiry on the 4th edge after the CTRL write
    bus_write(A_PRESC, 16'h0000);
    bus_write(A_COUNT, 16'h0003);
    bus_write(A_CTRL, 16'h0005);
    idle(3);
    check("os_irq_early", {15'b0, irq}, 16'h0000);
    idle(1);
    check("os_irq_4", {15'b0, irq}, 16'h0001);
    bus_read(A_CTRL, rd);   check("os_ctrl", rd, 16'h0004);
    bus_read(A_COUNT, rd);  check("os_count", rd, 16'h0000);
    bus_read(A_STATUS, rd); check("os_status", rd, 16'h0001);
    bus_write(A_STATUS, 16'h0001);
    check("os_irq_clr", {15'b0, irq}, 16'h0000);

    // 3. auto-reload, period 6 with PRESC=1 RELOAD=2
    bus_write(A_PRESC, 16'h0001);
    bus_write(A_RELOAD, 16'h0002);
    bus_write(A_COUNT, 16'h0002);
    bus_write(A_CTRL, 16'h0007);
    idle(5);
    check("ar_irq_p5", {15'b0, irq}, 16'h0000);
    idle(1);
    check("ar_irq_p6", {15'b0, irq}, 16'h0001);
    bus_write(A_STATUS, 16'h0001);
    check("ar_clr1", {15'b0, irq}, 16'h0000);
    idle(4);
    check("ar_irq_p11", {15'b0, irq}, 16'h0000);
    idle(1);
    check("ar_irq_p12", {15'b0, irq}, 16'h0001);
    bus_write(A_STATUS, 16'h0001);
    check("ar_clr2", {15'b0, irq}, 16'h0000);

    // 4. clear race: write-1-clear lands on the expiry edge (P18)
    idle(4);
    check("race_irq_pre", {15'b0, irq}, 16'h0000);
    bus_write(A_STATUS, 16'h0001);
    check("race_irq", {15'b0, irq}, 16'h0001);
    bus_read(A_STATUS, rd); check("race_status", rd, 16'h0001);
    bus_read(A_COUNT, rd);  check("race_count", rd, 16'h0001);
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_STATUS, 16'h0001);
    check("race_irq_off", {15'b0, irq}, 16'h0000);

    // 5. decode: unused CTRL bits read 0, bad addresses read 0 and ignore writes
    bus_write(A_RELOAD, 16'h1234);
    bus_write(A_COUNT, 16'h0055);
    bus_write(A_PRESC, 16'h0007);
    bus_write(A_CTRL, 16'hFFFE);
    bus_read(A_CTRL, rd); check("ctrl_bits", rd, 16'h0006);
    bus_write(A_CTRL, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      bus_read(A_RELOAD, rd);
      bus_read(bad_addrs[i], rd);
      check($sformatf("dec_rd_%h", bad_addrs[i]), rd, 16'h0000);
    end
    for (int i = 0; i < 3; i++) bus_write(bad_addrs[i], 16'hFFFF);
    reg_exp = '{16'h0000, 16'h1234, 16'h0055, 16'h0000, 16'h0007};
    for (int i = 0; i < 5; i++) begin
      bus_read(reg_addrs[i], rd);
      check($sformatf("dec_keep%0d", i), rd, reg_exp[i]);
    end
    check("dec_irq", {15'b0, irq}, 16'h0000);

    // 6. reset mid-count
    bus_write(A_PRESC, 16'h0000);
    bus_write(A_COUNT, 16'h0005);
    bus_write(A_CTRL, 16'h0005);
    idle(2);
    mon_en = 1'b1;
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(10);
    for (int i = 0; i < 5; i++) begin
      bus_read(reg_addrs[i], rd);
      check($sformatf("mid_rst_reg%0d", i), rd, 16'h0000);
    end
    mon_en = 1'b0;
    check("mid_rst_irq_hits", W'(irq_hits), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
